mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Iterative signed multiply/divide engine for the multicycle MIPS datapath. It sits directly downstream of the control FSM, which issues MULT_OP/DIV_OP and holds its MULT/DIV state for 32 iteration cycles. It consumes the A/B register operands and produces HI/LO results for the Hi/Lo registers (write enables stay with control).
- Multiply: radix-2 Booth.
- Divide: restoring division on magnitudes, followed by sign fix-up.

Parameters:
WIDTH, 32, operand width; hi/lo are WIDTH bits each; iteration count = WIDTH.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs
- start_mult  in  1  request signed multiply op_a*op_b; sampled only in IDLE
- start_div  in  1  request signed divide op_a/op_b; sampled only in IDLE
- op_a  in  WIDTH  multiplicand / dividend (from reg A)
- op_b  in  WIDTH  multiplier / divisor (from reg B)
- hi  out  WIDTH  product[63:32] or remainder
- lo  out  WIDTH  product[31:0] or quotient
- busy  out  1  high in RUN and FIXUP
- done  out  1  one-cycle pulse; hi/lo valid from this cycle on
- div_zero  out  1  high together with done when a divide had op_b==0; cleared on next accepted start

Behaviour:
- Reset (async, any state): state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0, internal regs=0. A reset in the middle of an operation abandons it; no done pulse.
- States: IDLE, RUN, FIXUP, DONE.
- IDLE:
  - start_mult=1 → latch operands; go to RUN with counter=0.
  - start_div=1 with op_b!=0 → latch |op_a|, |op_b| and both signs; go to RUN.
  - start_div=1 with op_b==0 → go directly to DONE; set div_zero=1; hi/lo unchanged.
  - start_mult and start_div both high → multiply wins.
- Operands are captured at the start edge. Later changes on op_a/op_b have no effect.
- Start inputs are ignored while busy=1 or in DONE; there is no queueing.
- RUN, multiply:
  - 33-bit sign-extended accumulator P_hi, 32-bit P_lo, plus a q_1 bit.
  - Each cycle, {P_lo[0],q_1} selects: 01 → P_hi+=M, 10 → P_hi-=M, otherwise no change. Then arithmetic-shift right {P_hi,P_lo,q_1} by 1.
  - The 33-bit width is required so that M=-2^31 does not overflow.
- RUN, divide:
  - Restoring division. Each cycle: shift {R,Q} left 1; trial = R - |divisor|; if trial >= 0, R=trial and Q[0]=1, else Q[0]=0.
- Counter increments every RUN cycle. After the 32nd iteration (counter==WIDTH-1 at the edge), go to FIXUP.
- FIXUP (1 cycle), registers hi/lo:
  - mult: hi=P_hi[31:0], lo=P_lo.
  - div: lo = Q, negated if sign_a^sign_b; hi = R, negated if sign_a (remainder takes the dividend's sign). Arithmetic is mod 2^32.
  - Hence -2^31 / -1 gives lo=0x80000000, hi=0.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency: start edge → 32 RUN cycles → 1 FIXUP cycle → done is high in the 34th cycle after the start edge. This fits inside the control FSM's MULT/DIV window plus its WAIT state.
- hi/lo hold their values until the next FIXUP, a div-by-zero (hi/lo left unchanged), or reset.

Decomposition:
- Shared package mips_pkg:
  - state encoding constants (IDLE/RUN/FIXUP/DONE)
  - WIDTH default
  - ITER_LAST = WIDTH-1
- One natural sub-module: md_step. It is combinational and computes one Booth or one restoring iteration, selected by an is_div input. The top level keeps the FSM, counter and registers.

Test Plan:
- start_mult, op_a=7, op_b=-3 → done in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high during cycles 1-33.
- start_mult, op_a=op_b=0x80000000 → hi=0x40000000, lo=0x00000000 (checks the 33-bit accumulator).
- start_div, op_a=-7, op_b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); div_zero=0.
- start_div, op_a=0x80000000, op_b=0xFFFFFFFF → lo=0x80000000, hi=0. Then start_div op_b=0 → done on the next cycle, div_zero=1, hi/lo unchanged.
- Assert start_div at cycle 10 of a running multiply, then change op_a → ignored; the multiply result is correct. Both starts in the same cycle → multiply result.
- Assert reset at cycle 15 of a divide → all outputs 0 immediately (asynchronously), no done pulse. A new start_mult 5*6 afterwards → lo=30, hi=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS datapath: operand width and
// the multiply/divide engine state encoding.
package mips_pkg;

  localparam int WIDTH     = 32;
  localparam int ITER_LAST = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FIXUP = 2'd2,
    S_DONE  = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_step.sv
// One iteration of the engine: a radix-2 Booth step (is_div=0) or one
// restoring-division step on magnitudes (is_div=1). Purely combinational.
module md_step
  import mips_pkg::*;
#(
  parameter int W = mips_pkg::WIDTH
) (
  input  logic         is_div,
  input  logic [W:0]   acc_i,
  input  logic [W-1:0] low_i,
  input  logic         q1_i,
  input  logic [W-1:0] m_i,
  output logic [W:0]   acc_o,
  output logic [W-1:0] low_o,
  output logic         q1_o
);

  logic [W:0] m_ext;
  logic [W:0] sum;
  logic [W:0] r_sh;
  logic [W:0] trial;

  always_comb begin
    m_ext = {m_i[W-1], m_i};
    sum   = acc_i;
    r_sh  = {acc_i[W-1:0], low_i[W-1]};
    trial = r_sh - {1'b0, m_i};
    acc_o = acc_i;
    low_o = low_i;
    q1_o  = 1'b0;
    if (!is_div) begin
      case ({low_i[0], q1_i})
        2'b01:   sum = acc_i + m_ext;
        2'b10:   sum = acc_i - m_ext;
        default: sum = acc_i;
      endcase
      // Arithmetic shift of {P_hi, P_lo, q_1}; the 33rd accumulator bit keeps M=-2^31 safe.
      acc_o = {sum[W], sum[W:1]};
      low_o = {sum[0], low_i[W-1:1]};
      q1_o  = low_i[0];
    end else if (!trial[W]) begin
      acc_o = trial;
      low_o = {low_i[W-2:0], 1'b1};
    end else begin
      acc_o = r_sh;
      low_o = {low_i[W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative signed multiply (Booth) / divide (restoring + sign fix-up) unit.
// Start edge -> WIDTH RUN cycles -> FIXUP -> one-cycle done pulse.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = mips_pkg::WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] low_q, low_d;
  logic             q1_q, q1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d, dz_q, dz_d;

  logic [WIDTH:0]   acc_nx;
  logic [WIDTH-1:0] low_nx;
  logic             q1_nx;

  md_step #(.W(WIDTH)) u_step (
    .is_div (is_div_q),
    .acc_i  (acc_q),
    .low_i  (low_q),
    .q1_i   (q1_q),
    .m_i    (m_q),
    .acc_o  (acc_nx),
    .low_o  (low_nx),
    .q1_o   (q1_nx)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    acc_d    = acc_q;
    low_d    = low_q;
    q1_d     = q1_q;
    m_d      = m_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          state_d  = S_RUN;
          is_div_d = 1'b0;
          acc_d    = '0;
          low_d    = op_b;
          q1_d     = 1'b0;
          m_d      = op_a;
          cnt_d    = '0;
          busy_d   = 1'b1;
          dz_d     = 1'b0;
        end else if (start_div) begin
          if (op_b == '0) begin
            // Divide by zero: report immediately, leave hi/lo untouched.
            state_d = S_DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end else begin
            state_d  = S_RUN;
            is_div_d = 1'b1;
            acc_d    = '0;
            low_d    = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
            q1_d     = 1'b0;
            m_d      = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
            sa_d     = op_a[WIDTH-1];
            sb_d     = op_b[WIDTH-1];
            cnt_d    = '0;
            busy_d   = 1'b1;
            dz_d     = 1'b0;
          end
        end
      end
      S_RUN: begin
        acc_d = acc_nx;
        low_d = low_nx;
        q1_d  = q1_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        if (is_div_q) begin
          lo_d = (sa_q ^ sb_q) ? (~low_q + 1'b1) : low_q;
          hi_d = sa_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
        end else begin
          hi_d = acc_q[WIDTH-1:0];
          lo_d = low_q;
        end
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_q    <= '0;
      low_q    <= '0;
      q1_q     <= 1'b0;
      m_q      <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      acc_q    <= acc_d;
      low_q    <= low_d;
      q1_q     <= q1_d;
      m_q      <= m_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: hand-computed results, latency, start
// masking, divide-by-zero and asynchronous reset behaviour.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  int checks = 0;
  int errors = 0;

  mult_div_unit dut (
    .clock    (clock),
    .reset    (reset),
    .start_mult(start_mult),
    .start_div(start_div),
    .op_a     (op_a),
    .op_b     (op_b),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a start for one edge; returns at #1 after the start edge (cycle 1).
  task automatic do_start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    start_mult = m;
    start_div  = d;
    op_a       = a;
    op_b       = b;
    @(posedge clock); #1;
    start_mult = 1'b0;
    start_div  = 1'b0;
  endtask

  // n = cycle index (1 = just after start edge) in which done is seen.
  task automatic wait_done(output int n, output logic busy_ok);
    n = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && n < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clock); #1;
      n++;
    end
  endtask

  int   n;
  logic bok;
  logic seen_done;

  initial begin
    // Reset state
    #1 reset = 1'b1;
    #2;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_flags", {29'd0, busy, done, div_zero}, 32'h0);
    @(posedge clock); #1 reset = 1'b0;

    // 7 * -3 = -21, plus latency and busy window
    do_start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    wait_done(n, bok);
    chk("mul1_latency", n, 34);
    chk("mul1_busy_window", {31'd0, bok}, 32'd1);
    chk("mul1_busy_at_done", {31'd0, busy}, 32'd0);
    chk("mul1_hi", hi, 32'hFFFF_FFFF);
    chk("mul1_lo", lo, 32'hFFFF_FFEB);
    @(posedge clock); #1;
    chk("mul1_done_pulse", {31'd0, done}, 32'd0);

    // (-2^31)^2 = 2^62
    do_start(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_done(n, bok);
    chk("mul2_hi", hi, 32'h4000_0000);
    chk("mul2_lo", lo, 32'h0000_0000);
    @(posedge clock); #1;

    // -7 / 2 = -3 rem -1
    do_start(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(n, bok);
    chk("div1_latency", n, 34);
    chk("div1_lo", lo, 32'hFFFF_FFFD);
    chk("div1_hi", hi, 32'hFFFF_FFFF);
    chk("div1_dz", {31'd0, div_zero}, 32'd0);
    @(posedge clock); #1;

    // -2^31 / -1 wraps to -2^31 rem 0
    do_start(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, bok);
    chk("div2_lo", lo, 32'h8000_0000);
    chk("div2_hi", hi, 32'h0);
    @(posedge clock); #1;

    // Divide by zero: immediate done, hi/lo unchanged
    do_start(1'b0, 1'b1, 32'd1234, 32'd0);
    chk("dz_done_next", {31'd0, done}, 32'd1);
    chk("dz_flag", {31'd0, div_zero}, 32'd1);
    chk("dz_lo_kept", lo, 32'h8000_0000);
    chk("dz_hi_kept", hi, 32'h0);
    @(posedge clock); #1;
    chk("dz_pulse_end", {31'd0, done}, 32'd0);
    chk("dz_flag_held", {31'd0, div_zero}, 32'd1);

    // 100 * -5 with a stray start_div and op changes mid-run
    do_start(1'b1, 1'b0, 32'd100, 32'hFFFF_FFFB);
    chk("dz_cleared_by_start", {31'd0, div_zero}, 32'd0);
    repeat (9) begin @(posedge clock); #1; end
    start_div = 1'b1;
    op_a = 32'd99;
    op_b = 32'd0;
    @(posedge clock); #1;
    start_div = 1'b0;
    n = 11;
    while (done !== 1'b1 && n < 100) begin @(posedge clock); #1; n++; end
    chk("ign_latency", n, 34);
    chk("ign_hi", hi, 32'hFFFF_FFFF);
    chk("ign_lo", lo, 32'hFFFF_FE0C);
    chk("ign_dz", {31'd0, div_zero}, 32'd0);
    @(posedge clock); #1;

    // Both starts together: multiply wins
    do_start(1'b1, 1'b1, 32'd6, 32'd7);
    wait_done(n, bok);
    chk("both_lo", lo, 32'd42);
    chk("both_hi", hi, 32'd0);
    @(posedge clock); #1;

    // Reset in cycle 15 of a divide
    do_start(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (14) begin @(posedge clock); #1; end
    #2 reset = 1'b1;
    #1;
    chk("arst_lo", lo, 32'h0);
    chk("arst_flags", {29'd0, busy, done, div_zero}, 32'h0);
    @(posedge clock); #1 reset = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    chk("arst_no_done", {31'd0, seen_done}, 32'd0);

    do_start(1'b1, 1'b0, 32'd5, 32'd6);
    wait_done(n, bok);
    chk("post_rst_lo", lo, 32'd30);
    chk("post_rst_hi", hi, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
